soc_irq_controller: RTL

//  Avalon-MM interrupt aggregator directly downstream of the interval timers and other SoC peripherals.

---
 rtl/soc_irq_pkg.sv | 26 ++
 rtl/soc_irq_prio_enc.sv | 24 ++
 rtl/soc_irq_controller.sv | 107 ++++++++++
 3 files changed

// File: rtl/soc_irq_pkg.sv
// Shared constants and types for the SoC interrupt controller.
//  - Avalon-MM word addresses of the eight registers
//  - VECTOR register field layout
//  - MAX_SRC: upper bound on the number of sources (4-bit index, 15 = room for all)
package soc_irq_pkg;

  localparam int DATA_W        = 16;
  localparam int VEC_VALID_BIT = 15;
  localparam int VEC_IDX_W     = 4;
  localparam int MAX_SRC       = 15;

  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_PENDING = 3'd1;
  localparam logic [2:0] ADDR_ENABLE  = 3'd2;
  localparam logic [2:0] ADDR_MODE    = 3'd3;
  localparam logic [2:0] ADDR_VECTOR  = 3'd4;
  localparam logic [2:0] ADDR_ACK     = 3'd5;
  localparam logic [2:0] ADDR_SWSET   = 3'd6;
  localparam logic [2:0] ADDR_ID      = 3'd7;

  typedef struct packed {
    logic                 valid;
    logic [VEC_IDX_W-1:0] idx;
  } vec_t;

endpackage

// File: rtl/soc_irq_prio_enc.sv
// Combinational lowest-index-first priority encoder.
//  req   in  NUM_SRC  request vector
//  valid out 1        any request set
//  idx   out 4        index of the lowest set request (0 when none)
module soc_irq_prio_enc
  import soc_irq_pkg::*;
#(
  parameter int NUM_SRC = 8
) (
  input  logic [NUM_SRC-1:0]   req,
  output logic                 valid,
  output logic [VEC_IDX_W-1:0] idx
);

  // Scan downward so the last hit, i.e. the lowest index, wins.
  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) idx = VEC_IDX_W'(i);
    end
  end

endmodule

// File: rtl/soc_irq_controller.sv
// Avalon-MM interrupt aggregator.
// Latches each peripheral irq line (level or rising-edge) into a pending bit,
// masks by a per-source enable, and produces a registered CPU irq plus a
// lowest-index-wins VECTOR register.
//  clk, reset   system clock, async active-high reset
//  address      3-bit word address
//  chipselect   slave select
//  write_n      active-low write strobe
//  writedata    16-bit write data
//  readdata     registered read data, 1-cycle latency, loaded every cycle
//  irq_src      NUM_SRC peripheral irq lines (synchronous to clk)
//  irq          registered interrupt to the CPU
module soc_irq_controller
  import soc_irq_pkg::*;
#(
  parameter int          NUM_SRC  = 8,
  parameter logic [15:0] ID_VALUE = 16'hC1A0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  input  logic [NUM_SRC-1:0] irq_src,
  output logic               irq
);

  logic               wr_en;
  logic [NUM_SRC-1:0] wdata_src;
  logic [NUM_SRC-1:0] pend, en, mode, src_prev;
  logic [NUM_SRC-1:0] pend_next, en_next, mode_next;
  logic [NUM_SRC-1:0] set_hw, set_sw, clr, ack_dec;
  logic               enc_valid;
  logic [VEC_IDX_W-1:0] enc_idx;
  vec_t               vec_q;
  logic [DATA_W-1:0]  rd_mux;
  logic               unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign wdata_src    = writedata[NUM_SRC-1:0];
  // Upper write data bits only matter for ACK/ID-less registers; parity keeps them referenced.
  assign unused_wdata = ^writedata;

  // ACK index decode; an index at or above NUM_SRC matches nothing.
  always_comb begin
    ack_dec = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (writedata[VEC_IDX_W-1:0] == VEC_IDX_W'(i)) ack_dec[i] = 1'b1;
    end
  end

  assign set_hw = (irq_src & ~src_prev & mode) | (irq_src & ~mode);
  assign set_sw = (wr_en && address == ADDR_SWSET) ? wdata_src : '0;
  assign clr    = ((wr_en && address == ADDR_PENDING) ? wdata_src : '0)
                | ((wr_en && address == ADDR_ACK)     ? ack_dec   : '0);

  // Set terms are ORed in after the clear so a coincident event is never lost.
  assign pend_next = (pend & ~clr) | set_hw | set_sw;
  assign en_next   = (wr_en && address == ADDR_ENABLE) ? wdata_src : en;
  assign mode_next = (wr_en && address == ADDR_MODE)   ? wdata_src : mode;

  soc_irq_prio_enc #(.NUM_SRC(NUM_SRC)) u_prio (
    .req   (pend & en),
    .valid (enc_valid),
    .idx   (enc_idx)
  );

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_STATUS:  rd_mux[NUM_SRC-1:0] = pend & en;
      ADDR_PENDING: rd_mux[NUM_SRC-1:0] = pend;
      ADDR_ENABLE:  rd_mux[NUM_SRC-1:0] = en;
      ADDR_MODE:    rd_mux[NUM_SRC-1:0] = mode;
      ADDR_VECTOR: begin
        rd_mux[VEC_VALID_BIT]   = vec_q.valid;
        rd_mux[VEC_IDX_W-1:0]   = vec_q.idx;
      end
      ADDR_ID:      rd_mux = ID_VALUE;
      default:      rd_mux = '0;   // ACK and SWSET are write-only
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend     <= '0;
      en       <= '0;
      mode     <= '0;
      src_prev <= '0;
      vec_q    <= '0;
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      pend     <= pend_next;
      en       <= en_next;
      mode     <= mode_next;
      src_prev <= irq_src;
      vec_q    <= '{valid: enc_valid, idx: enc_idx};
      readdata <= rd_mux;
      // Look ahead at next-state so irq follows the source edge by one cycle.
      irq      <= |(pend_next & en_next);
    end
  end

endmodule
